// File: rtl/step_sequencer.sv
// Step sequencer: plays a NUM_STEPS x 4-bit note pattern at TICKS_PER_STEP cycles per step.
// Latency: start/stop take effect on the edge that samples them; all outputs registered.
// Backpressure: none; free-running playback, pattern writes accepted in any state.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset (clears pattern and outputs)
//   start, stop             - transport pulses; stop wins when both are high
//   wr_en, wr_step, wr_note - pattern write; codes 9..15 are stored as rest (0)
//   note                    - current note code, {4'b0, code}
//   step_idx, step_pulse    - current step index and one-cycle strobe on step entry
//   playing                 - high while playing
// Optional feature macro: STEP_SEQUENCER_LOOP_EN (defined: wrap to step 0 forever;
// undefined: one-shot, return to idle after the last step).
module step_sequencer #(
    parameter int NUM_STEPS      = 8,
    parameter int TICKS_PER_STEP = 3_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_STEPS)-1:0] wr_step,
    input  logic [3:0]                   wr_note,
    output logic [7:0]                   note,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         step_pulse,
    output logic                         playing
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam int CW = $clog2(TICKS_PER_STEP);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_STEP - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(NUM_STEPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_pattern [NUM_STEPS];
    logic [CW-1:0]   r_tick;
    logic [SW-1:0]   r_step;
    logic [3:0]      r_note;
    logic            r_pulse;

    logic            w_enter;      // a step entry happens on this edge
    logic [SW-1:0]   w_enter_idx;  // index of the step being entered
    logic            w_to_idle;    // playback ends on this edge
    logic [3:0]      w_wr_code;

    // Out-of-range note codes are stored as rests.
    assign w_wr_code = (wr_note <= 4'd8) ? wr_note : 4'd0;

    // Next-state and step-entry decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_enter_idx = '0;
        w_to_idle   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // stop has priority over a simultaneous start
                if (start && !stop) begin
                    w_state_nxt = S_PLAY;
                    w_enter     = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_to_idle   = 1'b1;
                end else if (start) begin
                    // restart from step 0
                    w_enter = 1'b1;
                end else if (r_tick == TICK_LAST) begin
                    if (r_step == STEP_LAST) begin
`ifdef STEP_SEQUENCER_LOOP_EN
                        w_enter = 1'b1;
`else
                        w_state_nxt = S_IDLE;
                        w_to_idle   = 1'b1;
`endif
                    end else begin
                        w_enter     = 1'b1;
                        w_enter_idx = r_step + SW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_to_idle   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pattern storage. A step entry on the same edge reads the old value
    // because the read below samples r_pattern before this update lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_pattern[i] <= 4'd0;
            end
        end else if (wr_en) begin
            r_pattern[wr_step] <= w_wr_code;
        end
    end

    // Output registers and tick counter. The note is latched only at step entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick  <= '0;
            r_step  <= '0;
            r_note  <= 4'd0;
            r_pulse <= 1'b0;
        end else if (w_enter) begin
            r_tick  <= '0;
            r_step  <= w_enter_idx;
            r_note  <= r_pattern[w_enter_idx];
            r_pulse <= 1'b1;
        end else if (w_to_idle) begin
            r_tick  <= '0;
            r_step  <= '0;
            r_note  <= 4'd0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (r_state == S_PLAY) begin
                r_tick <= r_tick + CW'(1);
            end
        end
    end

    assign note       = {4'b0000, r_note};
    assign step_idx   = r_step;
    assign step_pulse = r_pulse;
    assign playing    = (r_state == S_PLAY);

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

    localparam int NS  = 4;
    localparam int TPS = 4;
`ifdef STEP_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_step = 2'd0;
    logic [3:0] wr_note = 4'd0;
    logic [7:0] note;
    logic [1:0] step_idx;
    logic       step_pulse;
    logic       playing;

    step_sequencer #(.NUM_STEPS(NS), .TICKS_PER_STEP(TPS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_step(wr_step), .wr_note(wr_note),
        .note(note), .step_idx(step_idx), .step_pulse(step_pulse), .playing(playing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] note;
        logic [1:0] idx;
        logic       pulse;
        logic       playing;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: playback position derived from the edge number of the last start.
    int   m_pat[NS];
    bit   m_play;
    int   m_base;
    int   m_note;
    int   m_idx;
    int   n_edge;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_pat[i] = 0;
        m_play = 0;
        m_base = 0;
        m_note = 0;
        m_idx  = 0;
    endtask

    task automatic chk(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got note=%0d idx=%0d pulse=%0b playing=%0b, want note=%0d idx=%0d pulse=%0b playing=%0b",
                     name, $time, got.note, got.idx, got.pulse, got.playing,
                     want.note, want.idx, want.pulse, want.playing);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, push the model's expectation.
    task automatic cyc(input bit s, input bit p, input bit we, input int ws, input int wn);
        exp_t e;
        int   d;
        int   k;
        start   = s;
        stop    = p;
        wr_en   = we;
        wr_step = 2'(ws);
        wr_note = 4'(wn);
        @(posedge clk);
        n_edge++;
        e.pulse = 1'b0;
        if (p) begin
            m_play = 0;
        end else if (s) begin
            m_play = 1;
            m_base = n_edge;
        end
        if (m_play) begin
            d = n_edge - m_base;
            if (d % TPS == 0) begin
                k = d / TPS;
                if (!LOOP && k >= NS) begin
                    m_play = 0;
                end else begin
                    m_idx   = k % NS;
                    m_note  = m_pat[m_idx];
                    e.pulse = 1'b1;
                end
            end
        end
        if (!m_play) begin
            m_idx  = 0;
            m_note = 0;
        end
        e.note    = 8'(m_note);
        e.idx     = 2'(m_idx);
        e.playing = m_play;
        exp_q.push_back(e);
        // write lands after the read of this edge
        if (we) m_pat[ws] = (wn > 8) ? 0 : wn;
        @(negedge clk);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare against the queued expectation.
    always @(posedge clk) begin
        exp_t want;
        exp_t got;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {note, step_idx, step_pulse, playing};
            chk("cycle", got, want);
        end
    end

    initial begin
        exp_t zero;
        exp_t got;
        zero   = '0;
        n_edge = 0;
        model_reset();

        // reset state
        #12;
        got = {note, step_idx, step_pulse, playing};
        chk("reset_state", got, zero);
        @(negedge clk);
        rst_n = 1'b1;

        // pattern {1,3,5,8}, then play one full pass plus the wrap/end point
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 3);
        cyc(0, 0, 1, 2, 5);
        cyc(0, 0, 1, 3, 8);
        cyc(1, 0, 0, 0, 0);
        idle(20);

        // out-of-range code stored as rest; in-flight write to current step
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 2, 12);
        cyc(1, 0, 0, 0, 0);
        idle(5);
        cyc(0, 0, 1, 1, 7);
        idle(18);

        // simultaneous start and stop while playing
        cyc(1, 0, 0, 0, 0);
        idle(3);
        cyc(1, 1, 0, 0, 0);
        idle(2);
        // stop while idle, start+stop while idle
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle(2);

        // restart mid-step: start at T, again at T+6
        cyc(1, 0, 0, 0, 0);
        idle(5);
        cyc(1, 0, 0, 0, 0);
        idle(10);

        // write and entry to the same index on the same edge
        cyc(1, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 1, 2);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 20, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end

        // asynchronous reset mid step 2
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 2, 6);
        cyc(1, 0, 0, 0, 0);
        idle(9);
        #2;
        rst_n = 1'b0;
        #1;
        got = {note, step_idx, step_pulse, playing};
        chk("async_reset", got, zero);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        idle(20);

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Pattern-playback controller for the note datapath. Holds a small step pattern of 4-bit note codes: 0 is rest, 1–8 are C4 to C5. Steps through the pattern at a fixed tempo and drives the 8-bit note code consumed by the seven-segment display decoder and the tone generator. Sits between the user-input logic (buttons/switches, edit and transport commands) and every note consumer.

## Interface
Parameters:
- NUM_STEPS, default 8: pattern length; must be a power of two, minimum 2.
- TICKS_PER_STEP, default 3_000_000: clock cycles per step (4 steps/s at 12 MHz); minimum 2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse; begin or restart playback at step 0.
- stop, input, 1: one-cycle pulse; halt playback.
- wr_en, input, 1: pattern write strobe.
- wr_step, input, $clog2(NUM_STEPS): step index to write.
- wr_note, input, 4: note code to write.
- note, output, 8: current note code, upper 4 bits always 0.
- step_idx, output, $clog2(NUM_STEPS): index of the step being played.
- step_pulse, output, 1: one-cycle strobe on each step entry.
- playing, output, 1: high while in PLAY.

## Operation
- Pattern storage is NUM_STEPS × 4-bit registers. Reset clears every entry to 0 (rest).
- Write: when wr_en is high, pattern[wr_step] ← wr_note on that edge. Codes 9–15 are stored as 0.
- Writes are accepted in any state.
- State machine has two states:
  - IDLE: note = 0, step_idx = 0, tick counter = 0, playing = 0.
  - PLAY: playing = 1. The tick counter counts 0 … TICKS_PER_STEP−1.
- IDLE → PLAY on start.
- PLAY → IDLE on stop, or at the end of the last step when loop is disabled (see Configuration).
- Step entry actions:
  - step_idx takes the new index.
  - note is registered from pattern[new index].
  - step_pulse = 1 for one cycle.
  - tick counter resets to 0.
- The note register is latched only at step entry. A write to the current step changes the output on that step's next visit, not immediately.
- If a write and a step entry hit the same index in the same cycle, the entry latches the old value (read-before-write).
- Simultaneous start and stop: stop wins; the block goes to IDLE.
- start while in PLAY: restart. Step 0 is entered on the next cycle and the counter is cleared.
- stop while in IDLE: no effect.
- Reset mid-playback: all outputs go to reset values immediately (asynchronous), and the pattern is cleared.

## Timing
- Reset values: note = 8'h00, step_idx = 0, step_pulse = 0, playing = 0.
- Start latency: start sampled at edge T. At T+1: playing = 1, step_idx = 0, note = pattern[0], step_pulse = 1.
- Step period is exactly TICKS_PER_STEP cycles. The k-th step entry after start occurs at edge T+1+k·TICKS_PER_STEP.
- Stop latency: stop sampled at edge T. At T+1: playing = 0, note = 0, step_idx = 0, step_pulse = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Write latency: pattern updated at the sampling edge; visible to a step entry from the following edge.

## Configuration
- Macro: STEP_SEQUENCER_LOOP_EN.
- Defined: after step NUM_STEPS−1 completes, the block wraps to step 0 and keeps playing until stop.
- Not defined (one-shot mode): after step NUM_STEPS−1 completes, the block returns to IDLE in place of the next step entry. It outputs note = 0, step_idx = 0, playing = 0, and no step_pulse.

## Test plan
All scenarios use NUM_STEPS = 4 and TICKS_PER_STEP = 4.
- Reset, then write pattern {1,3,5,8}, then start at T. Required response:
  - note = 1, 3, 5, 8 at T+1, T+5, T+9, T+13.
  - step_pulse high exactly on those cycles.
- Same pattern, continuing from the scenario above. Required response:
  - With LOOP_EN: note = 1 and step_idx = 0 at T+17.
  - Without LOOP_EN: playing = 0 and note = 0 at T+17, with no step_pulse.
- Write wr_note = 12 to step 2, then play. Required response: note = 0 during step 2.
- During step 1 playback (pattern value 3), write 7 to step 1. Required response:
  - note stays 3 for the rest of step 1.
  - With LOOP_EN, the next visit to step 1 shows 7.
- Assert start and stop in the same cycle while playing. Required response: IDLE next cycle, note = 0.
- Pulse start at T+6 while playing. Required response:
  - At T+7: step_idx = 0, step_pulse = 1.
  - Next step entry at T+11.
- Drive rst_n low mid-step 2, between clock edges. Required response:
  - Outputs go to reset values without waiting for a clock edge.
  - After release, start plays all rests (note = 0 for every step).
